// File: rtl/dut_core.sv
// Register-mapped programmable 8-bit counter.
// Host port: 8 x 8-bit registers, 1-cycle registered read.
module dut_core (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       write_en,
  input  logic [2:0] write_address,
  input  logic [7:0] write_data,
  input  logic       read_en,
  input  logic [2:0] read_address,
  output logic [7:0] read_data,
  output logic [7:0] counter_out
);

  localparam logic [7:0] ID_VAL = 8'hA5;

  logic [2:0] ctrl_q;
  logic [7:0] load_q;
  logic [7:0] step_q;
  logic [7:0] limit_q;
  logic       hit_q;
  logic [7:0] scratch_q;
  logic [7:0] count_q;

  logic en, dir, oneshot;
  logic wr_ctrl, wr_load, wr_step;
  logic wr_limit, wr_status, wr_scratch;
  logic hit_ev;
  logic [7:0] count_d;
  logic [7:0] rd_mux;

  assign en      = ctrl_q[0];
  assign dir     = ctrl_q[1];
  assign oneshot = ctrl_q[2];

  assign wr_ctrl    = write_en && (write_address == 3'd0);
  assign wr_load    = write_en && (write_address == 3'd1);
  assign wr_step    = write_en && (write_address == 3'd2);
  assign wr_limit   = write_en && (write_address == 3'd3);
  assign wr_status  = write_en && (write_address == 3'd4);
  assign wr_scratch = write_en && (write_address == 3'd6);

  // A LOAD write outranks the limit compare, so it never raises HIT.
  assign hit_ev = !wr_load && en && (count_q == limit_q);

  always_comb begin
    count_d = count_q;
    if (wr_load)
      count_d = write_data;
    else if (hit_ev)
      count_d = load_q;
    else if (en)
      count_d = dir ? count_q - step_q
                    : count_q + step_q;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (read_address)
      3'd0: rd_mux = {5'b0, ctrl_q};
      3'd1: rd_mux = load_q;
      3'd2: rd_mux = step_q;
      3'd3: rd_mux = limit_q;
      3'd4: rd_mux = {7'b0, hit_q};
      3'd5: rd_mux = count_q;
      3'd6: rd_mux = scratch_q;
      3'd7: rd_mux = ID_VAL;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ctrl_q    <= 3'b000;
      load_q    <= 8'h00;
      step_q    <= 8'h01;
      limit_q   <= 8'hFF;
      hit_q     <= 1'b0;
      scratch_q <= 8'h00;
      count_q   <= 8'h00;
      read_data <= 8'h00;
    end else begin
      count_q <= count_d;
      // Host CTRL write beats the one-shot EN clear.
      if (wr_ctrl)
        ctrl_q <= write_data[2:0];
      else if (hit_ev && oneshot)
        ctrl_q <= {ctrl_q[2:1], 1'b0};
      if (wr_load)
        load_q <= write_data;
      if (wr_step)
        step_q <= write_data;
      if (wr_limit)
        limit_q <= write_data;
      if (wr_scratch)
        scratch_q <= write_data;
      if (hit_ev)
        hit_q <= 1'b1;
      else if (wr_status && write_data[0])
        hit_q <= 1'b0;
      if (read_en)
        read_data <= rd_mux;
    end
  end

  assign counter_out = count_q;

endmodule

// File: tb/tb_dut_core.sv
// Bench for dut_core: directed steps plus random traffic
// checked against a register-level reference model.
module tb_dut_core;

  logic       CLK;
  logic       RST_N;
  logic       write_en;
  logic [2:0] write_address;
  logic [7:0] write_data;
  logic       read_en;
  logic [2:0] read_address;
  logic [7:0] read_data;
  logic [7:0] counter_out;

  int total;
  int bad;

  // reference model state
  int m_reg[8];
  int m_cnt;
  int m_rd;
  logic [7:0] rst_vals[8];

  dut_core u_dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .write_en(write_en),
    .write_address(write_address),
    .write_data(write_data),
    .read_en(read_en),
    .read_address(read_address),
    .read_data(read_data),
    .counter_out(counter_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h",
             tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_reg[0] = 0;   m_reg[1] = 0;
    m_reg[2] = 1;   m_reg[3] = 255;
    m_reg[4] = 0;   m_reg[5] = 0;
    m_reg[6] = 0;   m_reg[7] = 165;
    m_cnt = 0;
    m_rd  = 0;
  endtask

  function automatic int mread(input int a);
    if (a == 5) return m_cnt;
    return m_reg[a];
  endfunction

  // one clock: model the edge, drive, then check after it
  task automatic tick(input logic we, input int wa,
                      input int wd, input logic re,
                      input int ra);
    int nxt;
    bit en, hit;
    @(negedge CLK);
    write_en      = we;
    write_address = wa[2:0];
    write_data    = wd[7:0];
    read_en       = re;
    read_address  = ra[2:0];
    if (re) m_rd = mread(ra);
    en  = m_reg[0] % 2 == 1;
    hit = 0;
    if (we && wa == 1)
      nxt = wd;
    else if (en && m_cnt == m_reg[3]) begin
      nxt = m_reg[1];
      hit = 1;
    end else if (en && m_reg[0] / 2 % 2 == 1)
      nxt = (m_cnt - m_reg[2] + 256) % 256;
    else if (en)
      nxt = (m_cnt + m_reg[2]) % 256;
    else
      nxt = m_cnt;
    m_cnt = nxt;
    if (hit && m_reg[0] >= 4) m_reg[0] = m_reg[0] - 1;
    if (we) begin
      case (wa)
        0: m_reg[0] = wd % 8;
        1, 2, 3, 6: m_reg[wa] = wd;
        4: if (wd % 2 == 1) m_reg[4] = 0;
        default: ;
      endcase
    end
    if (hit) m_reg[4] = 1;
    @(posedge CLK);
    #1;
    chk("counter_out", counter_out, m_cnt[7:0]);
    chk("read_data", read_data, m_rd[7:0]);
  endtask

  task automatic wr(input int a, input int d);
    tick(1'b1, a, d, 1'b0, 0);
  endtask

  task automatic rd(input int a);
    tick(1'b0, 0, 0, 1'b1, a);
  endtask

  task automatic idle();
    tick(1'b0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_vals[0] = 8'h00; rst_vals[1] = 8'h00;
    rst_vals[2] = 8'h01; rst_vals[3] = 8'hFF;
    rst_vals[4] = 8'h00; rst_vals[5] = 8'h00;
    rst_vals[6] = 8'h00; rst_vals[7] = 8'hA5;
    mreset();
    RST_N = 1'b0;
    write_en = 1'b0;
    write_address = 3'd0;
    write_data = 8'h00;
    read_en = 1'b0;
    read_address = 3'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_count", counter_out, 8'h00);
    chk("rst_rdata", read_data, 8'h00);
    for (int a = 0; a < 8; a++) begin
      rd(a);
      chk("rst_reg", read_data, rst_vals[a]);
    end

    // step 3 upward
    wr(2, 3);
    wr(0, 1);
    chk("en_latency", counter_out, 8'h00);
    idle(); chk("up1", counter_out, 8'h03);
    idle(); chk("up2", counter_out, 8'h06);
    idle(); chk("up3", counter_out, 8'h09);
    rd(5);
    chk("count_pre", read_data, 8'h09);
    chk("count_post", counter_out, 8'h0C);

    // limit reload and sticky HIT
    wr(0, 0);
    wr(1, 8'h10);
    wr(3, 8'h14);
    wr(2, 2);
    wr(0, 1);
    chk("ld", counter_out, 8'h10);
    idle(); chk("lim1", counter_out, 8'h12);
    idle(); chk("lim2", counter_out, 8'h14);
    idle(); chk("lim3", counter_out, 8'h10);
    rd(4);
    chk("hit_set", read_data, 8'h01);
    wr(4, 1);
    rd(4);
    chk("hit_clr", read_data, 8'h00);
    idle();
    idle();
    wr(4, 1);
    rd(4);
    chk("hit_w1c_race", read_data, 8'h01);

    // downward wrap
    wr(0, 0);
    wr(1, 1);
    wr(2, 2);
    wr(3, 8'h80);
    wr(0, 3);
    chk("dn0", counter_out, 8'h01);
    idle(); chk("dn1", counter_out, 8'hFF);
    idle(); chk("dn2", counter_out, 8'hFD);

    // one-shot
    wr(0, 0);
    wr(1, 0);
    wr(3, 2);
    wr(2, 1);
    wr(0, 5);
    idle(); chk("os1", counter_out, 8'h01);
    idle(); chk("os2", counter_out, 8'h02);
    idle(); chk("os3", counter_out, 8'h00);
    idle(); chk("os_hold", counter_out, 8'h00);
    rd(0);
    chk("os_ctrl", read_data, 8'h04);

    // read-only and scratch
    wr(7, 8'h12);
    wr(5, 8'h34);
    rd(7);
    chk("id_ro", read_data, 8'hA5);
    rd(5);
    chk("count_ro", read_data, 8'h00);
    wr(6, 8'h5A);
    rd(6);
    chk("scratch", read_data, 8'h5A);
    tick(1'b1, 6, 8'h77, 1'b1, 6);
    chk("rw_same", read_data, 8'h5A);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int wa, wd;
      wa = $urandom_range(0, 7);
      case (wa)
        0: wd = $urandom_range(0, 7) | 1;
        1, 3: wd = $urandom_range(0, 15);
        2: wd = $urandom_range(0, 3);
        4: wd = $urandom_range(0, 3);
        default: wd = $urandom_range(0, 255);
      endcase
      tick(($urandom % 4) == 0, wa, wd,
           ($urandom % 2) == 1, $urandom_range(0, 7));
    end

    // reset mid-count
    wr(0, 1);
    idle();
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_count", counter_out, 8'h00);
    chk("mid_rst_rdata", read_data, 8'h00);
    mreset();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(a);
      chk("rerst_reg", read_data, rst_vals[a]);
    end
    idle();
    chk("rerst_hold", counter_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
